// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-request front-end and its
// surrounding 8-bit barrel shifter.
package shift_pkg;

  localparam int DW  = 8;
  localparam int SHW = 3;

  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;
  localparam logic ARITH_LOGIC = 1'b0;
  localparam logic ARITH_ARITH = 1'b1;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [SHW-1:0] shamt;
    logic           dir;
    logic           arith;
  } req_t;

  localparam int REQ_W = DW + SHW + 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/shift_req_fifo.sv
// Generic synchronous FIFO with a combinational head output.
// DEPTH must be a power of two so the pointers wrap on their own.
module shift_req_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty_o gates every consumer of head_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/shift_issue.sv
// Registered front-end for the 8-bit barrel shifter: buffers requests,
// drives the shifter from the FIFO head and holds one result for downstream.
module shift_issue
  import shift_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic             in_arith,
  output logic [DW-1:0]    sh_din,
  output logic [SHW-1:0]   sh_shift,
  output logic             sh_dir,
  output logic             sh_arith,
  input  logic [DW-1:0]    sh_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_lost,
  output logic [CNT_W-1:0] done_cnt
);

  // A set bit falls off the end when it lies outside the surviving window.
  function automatic logic calc_lost(input logic [DW-1:0]  d,
                                     input logic [SHW-1:0] s,
                                     input logic           dir);
    logic [DW-1:0] keep;
    if (dir == DIR_LEFT) keep = {DW{1'b1}} >> s;
    else                 keep = {DW{1'b1}} << s;
    return |(d & ~keep);
  endfunction

  req_t             push_req, head_req;
  logic             fifo_full, fifo_empty, pop;
  slot_state_e      state_q, state_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_lost_q, out_lost_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  assign push_req = '{data: in_data, shamt: in_shamt, dir: in_dir, arith: in_arith};
  assign in_ready = !fifo_full;

  shift_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .din_i   (push_req),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_req)
  );

  assign sh_din   = fifo_empty ? '0   : head_req.data;
  assign sh_shift = fifo_empty ? '0   : head_req.shamt;
  assign sh_dir   = fifo_empty ? 1'b0 : head_req.dir;
  assign sh_arith = fifo_empty ? 1'b0 : head_req.arith;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_lost_d = out_lost_q;
    done_cnt_d = done_cnt_q;
    pop        = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (out_ready) begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
          if (!fifo_empty) pop = 1'b1;
          else             state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (pop) begin
      out_data_d = sh_dout;
      out_lost_d = calc_lost(head_req.data, head_req.shamt, head_req.dir);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      out_data_q <= '0;
      out_lost_q <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_lost_q <= out_lost_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = out_data_q;
  assign out_lost  = out_lost_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with a behavioural barrel shifter on the
// sh_* loop.
module tb_shift_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic       in_dir, in_arith;
  logic [7:0] sh_din;
  logic [2:0] sh_shift;
  logic       sh_dir, sh_arith;
  logic [7:0] sh_dout;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_lost;
  logic [7:0] done_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_issue #(.DEPTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .in_arith  (in_arith),
    .sh_din    (sh_din),
    .sh_shift  (sh_shift),
    .sh_dir    (sh_dir),
    .sh_arith  (sh_arith),
    .sh_dout   (sh_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lost  (out_lost),
    .done_cnt  (done_cnt)
  );

  // Downstream barrel shifter stand-in.
  always_comb begin
    sh_dout = 8'h00;
    if (sh_dir == 1'b0)      sh_dout = sh_din << sh_shift;
    else if (sh_arith)       sh_dout = 8'($signed(sh_din) >>> sh_shift);
    else                     sh_dout = sh_din >> sh_shift;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic dir, input logic ar);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_dir   = dir;
    in_arith = ar;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One isolated request with out_ready held high; checks result after 2 edges.
  task automatic send_one(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic dir, input logic ar,
                          input logic [7:0] exp_d, input logic exp_l);
    out_ready = 1'b1;
    drive(1'b1, d, s, dir, ar);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_lost"}, out_lost, exp_l);
    step();
    chk({tag, "_drain"}, out_valid, 0);
  endtask

  // Back-to-back stream of n requests (data=i, left by 1) with out_ready=1.
  task automatic stream(input string tag, input int n);
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    int bad = 0;
    logic ir_drop = 1'b0;
    logic [7:0] idx;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < n + 20 && got < n; cyc++) begin
      if (out_valid) begin
        idx = got[7:0];
        if (out_data !== 8'(idx << 1) || out_lost !== idx[7]) bad++;
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (sent < n) begin
        if (!in_ready) ir_drop = 1'b1;
        drive(1'b1, sent[7:0], 3'd1, 1'b0, 1'b0);
        sent++;
      end else begin
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      end
      step();
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk({tag, "_count"}, got, n);
    chk({tag, "_order_errs"}, bad, 0);
    chk({tag, "_first_lat"}, first, 2);
    chk({tag, "_back_to_back"}, last - first, n - 1);
    chk({tag, "_in_ready_drop"}, ir_drop, 0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_lost", out_lost, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sh_din", sh_din, 8'h00);
    rst = 1'b0;
    step();

    // 0x81 << 1: latency and counter
    drive(1'b1, 8'h81, 3'd1, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("t1_valid_n", out_valid, 0);
    chk("t1_sh_din", sh_din, 8'h81);
    chk("t1_sh_shift", sh_shift, 3'd1);
    step();
    chk("t1_valid_n1", out_valid, 1);
    chk("t1_data", out_data, 8'h02);
    chk("t1_lost", out_lost, 1);
    chk("t1_sh_empty", sh_din, 8'h00);
    out_ready = 1'b1;
    step();
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_drain", out_valid, 0);

    send_one("arith_r", 8'h80, 3'd3, 1'b1, 1'b1, 8'hF0, 1'b0);
    send_one("logic_r", 8'h0F, 3'd4, 1'b1, 1'b0, 8'h00, 1'b1);
    send_one("zero_sh", 8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0);
    send_one("left_ar", 8'h40, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("cnt_after_sends", done_cnt, 5);

    // Backpressure with a two-entry FIFO
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 3'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h02, 3'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h03, 3'd1, 1'b0, 1'b0);
    step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h02);
    drive(1'b1, 8'h04, 3'd1, 1'b0, 1'b0);
    step();
    chk("bp_in_ready2", in_ready, 0);
    chk("bp_hold", out_data, 8'h02);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("bp_hold2", out_data, 8'h02);
    chk("bp_cnt_stall", done_cnt, 5);
    out_ready = 1'b1;
    step();
    chk("bp_res_b", out_data, 8'h04);
    chk("bp_res_b_v", out_valid, 1);
    step();
    chk("bp_res_c", out_data, 8'h06);
    chk("bp_res_c_v", out_valid, 1);
    step();
    chk("bp_no_4th", out_valid, 0);
    chk("bp_cnt", done_cnt, 8);

    // Streaming from a clean counter
    do_reset();
    stream("s16", 16);
    chk("s16_done_cnt", done_cnt, 16);

    // Reset while full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h11, 3'd1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("mr_pre_full", in_ready, 0);
    chk("mr_pre_valid", out_valid, 1);
    do_reset();
    chk("mr_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_done_cnt", done_cnt, 0);
    chk("mr_data", out_data, 8'h00);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("mr_no_stale", seen, 0);
    chk("mr_cnt_after", done_cnt, 0);

    // Counter wrap
    stream("s257", 257);
    chk("wrap_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
